// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared types and constants for the I2S transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Default link geometry. stereo_sample_t is sized from c_word_len, so the
    // transmitter WORD_LEN parameter has to stay equal to this value.
    localparam int c_word_len   = 24;
    localparam int c_frame_len  = 64;
    localparam int c_fifo_depth = 2;

    // Explicit state encodings used by the transmitter FSM
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_left  = 2'd1;
    localparam logic [1:0] c_st_right = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = c_st_idle,
        LEFT  = c_st_left,
        RIGHT = c_st_right
    } i2s_tx_state_e;

    typedef struct packed {
        logic [c_word_len-1:0] left;
        logic [c_word_len-1:0] right;
    } stereo_sample_t;

    // Number of BCLK periods in one channel slot
    function automatic int half_frame_len(input int frame_len);
        return frame_len / 2;
    endfunction

    localparam int c_half_frame_len = half_frame_len(c_frame_len);

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2s_sample_fifo
// Description : Synchronous first-word-fall-through FIFO of stereo pairs with
//               flush, full/empty flags and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  stereo_sample_t                i_data,
    input  logic                          i_pop,
    output stereo_sample_t                o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);

    stereo_sample_t          r_mem [FIFO_DEPTH];
    logic [c_addr_w:0]       r_wr_ptr;
    logic [c_addr_w:0]       r_rd_ptr;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_do_push;
    logic                    w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                       (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Pointer update; flush discards all stored pairs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are meaningless while the pointers say empty
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule : i2s_sample_fifo
`default_nettype wire

// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : i2s_transmitter
// Description : Philips-format I2S serial-data transmitter. Buffers stereo
//               pairs and shifts them out MSB-first one BCLK after each
//               LRCLK edge, using externally generated bclk/lrclk.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int I2S_AUDIO_WORD_LEN  = c_word_len,
    parameter int I2S_AUDIO_FRAME_LEN = c_frame_len,
    parameter int FIFO_DEPTH          = c_fifo_depth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          bclk_i,
    input  logic                          lrclk_i,
    input  logic [I2S_AUDIO_WORD_LEN-1:0] left_data_i,
    input  logic [I2S_AUDIO_WORD_LEN-1:0] right_data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          audio_data_o,
    output logic                          pair_taken_o,
    output logic                          underrun_o
);

    localparam int c_half_len = half_frame_len(I2S_AUDIO_FRAME_LEN);
    localparam int c_cnt_w    = $clog2(c_half_len);
    localparam int c_fcnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_wl       = I2S_AUDIO_WORD_LEN;

    localparam logic [c_cnt_w-1:0]  c_word_cnt  = c_wl[c_cnt_w-1:0];
    localparam logic [c_fcnt_w-1:0] c_depth_cnt = FIFO_DEPTH[c_fcnt_w-1:0];

    // Edge detection
    logic                   r_bclk_q;
    logic                   r_lr_prev;
    logic                   w_fall;
    logic                   w_half_start;

    // FSM
    i2s_tx_state_e          r_state;
    i2s_tx_state_e          w_state_next;
    logic                   w_load_left;
    logic                   w_load_right;
    logic                   w_flush;
    logic                   w_pop;
    logic                   w_underrun;

    // Datapath
    logic [c_wl-1:0]        r_shift;
    logic [c_wl-1:0]        r_hold_right;
    logic [c_cnt_w-1:0]     r_bit_cnt;
    logic                   r_sd;
    logic                   r_ready;
    logic                   r_pair_taken;
    logic                   r_underrun;

    // FIFO interface
    stereo_sample_t         w_fifo_wr;
    stereo_sample_t         w_fifo_rd;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [c_fcnt_w-1:0]    w_fifo_count;
    logic [c_fcnt_w-1:0]    w_count_next;
    logic                   w_push;

    // bclk_i/lrclk_i are registered in this clock domain, so no synchroniser
    assign w_fall       = r_bclk_q & ~bclk_i;
    assign w_half_start = w_fall && (lrclk_i != r_lr_prev);

    assign w_fifo_wr    = '{left: left_data_i, right: right_data_i};
    assign w_push       = valid_i && r_ready && !w_fifo_full;

    i2s_sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (w_fifo_wr),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Track BCLK level and the LRCLK value seen at the previous BCLK fall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bclk_q  <= 1'b0;
            r_lr_prev <= 1'b0;
        end else begin
            r_bclk_q <= bclk_i;
            if (w_fall) r_lr_prev <= lrclk_i;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state and per-half load strobes; IDLE only leaves at a left start
    always_comb begin
        w_state_next = r_state;
        w_load_left  = 1'b0;
        w_load_right = 1'b0;
        w_flush      = 1'b0;
        if (!enable_i) begin
            w_state_next = IDLE;
            w_flush      = 1'b1;
        end else if (w_half_start) begin
            case (r_state)
                IDLE: begin
                    if (!lrclk_i) begin
                        w_state_next = LEFT;
                        w_load_left  = 1'b1;
                    end
                end
                LEFT: begin
                    if (lrclk_i) begin
                        w_state_next = RIGHT;
                        w_load_right = 1'b1;
                    end
                end
                RIGHT: begin
                    if (!lrclk_i) begin
                        w_state_next = LEFT;
                        w_load_left  = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
        w_pop      = w_load_left && !w_fifo_empty;
        w_underrun = w_load_left &&  w_fifo_empty;
    end

    // Occupancy after this clock, so ready_o never lags a fill by one cycle
    assign w_count_next = w_fifo_count
                        + {{(c_fcnt_w-1){1'b0}}, w_push}
                        - {{(c_fcnt_w-1){1'b0}}, w_pop};

    // Handshake ready and single-cycle status pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ready      <= 1'b0;
            r_pair_taken <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_ready      <= enable_i && (w_count_next < c_depth_cnt);
            r_pair_taken <= w_pop;
            r_underrun   <= w_underrun;
        end
    end

    // Shift register, bit counter and SD: pad bit at the start fall, then
    // WORD_LEN data bits, then zeros until the next half-frame start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift      <= '0;
            r_hold_right <= '0;
            r_bit_cnt    <= '0;
            r_sd         <= 1'b0;
        end else if (w_flush) begin
            r_shift      <= '0;
            r_hold_right <= '0;
            r_bit_cnt    <= '0;
            r_sd         <= 1'b0;
        end else if (w_load_left) begin
            r_shift      <= w_pop ? w_fifo_rd.left  : '0;
            r_hold_right <= w_pop ? w_fifo_rd.right : '0;
            r_bit_cnt    <= '0;
            r_sd         <= 1'b0;
        end else if (w_load_right) begin
            r_shift      <= r_hold_right;
            r_bit_cnt    <= '0;
            r_sd         <= 1'b0;
        end else if (w_fall) begin
            if (r_state == IDLE) begin
                r_sd <= 1'b0;
            end else if (r_bit_cnt < c_word_cnt) begin
                r_sd      <= r_shift[c_wl-1];
                r_shift   <= {r_shift[c_wl-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
                r_sd <= 1'b0;
            end
        end
    end

    assign ready_o      = r_ready;
    assign audio_data_o = r_sd;
    assign pair_taken_o = r_pair_taken;
    assign underrun_o   = r_underrun;

endmodule : i2s_transmitter
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : tb_i2s_transmitter
// Description : Self-checking bench for i2s_transmitter with a bench-side
//               bclk/lrclk source and a behavioural I2S receiver model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_transmitter;

    localparam int WL           = 24;
    localparam int FL           = 64;
    localparam int CLK_DIVISION = 14;
    localparam int HALF_BCLK    = CLK_DIVISION / 2;
    localparam int GUARD        = 3000;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b0;
    logic          bclk_i = 1'b0;
    logic          lrclk_i = 1'b0;
    logic [WL-1:0] left_data_i = '0;
    logic [WL-1:0] right_data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          audio_data_o;
    logic          pair_taken_o;
    logic          underrun_o;

    always #12.5 clk = ~clk;   // 40 MHz

    i2s_transmitter #(
        .I2S_AUDIO_WORD_LEN  (WL),
        .I2S_AUDIO_FRAME_LEN (FL),
        .FIFO_DEPTH          (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .bclk_i       (bclk_i),
        .lrclk_i      (lrclk_i),
        .left_data_i  (left_data_i),
        .right_data_i (right_data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .audio_data_o (audio_data_o),
        .pair_taken_o (pair_taken_o),
        .underrun_o   (underrun_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [WL-1:0] l; logic [WL-1:0] r; } pair_t;
    pair_t         mdl_q[$];
    bit            mdl_active = 0;
    logic [WL-1:0] mdl_held = '0;
    int            exp_taken = 0, exp_underrun = 0;

    // receiver view of the current half-frame
    logic [WL-1:0] cur_exp = '0;
    bit            cur_valid = 0, cur_skip = 0;
    int            rise_idx = 0, nbits = 0;
    logic [WL-1:0] rx_word = '0;
    logic          rx_extra = 1'b0;

    // bclk/lrclk source state
    int            tick = 0, fall_idx = 0, cur_half_len = FL / 2;
    bit            short_next_left = 0;

    int got_taken = 0, got_underrun = 0, got_both = 0, idle_pulse = 0;

    task automatic model_flush();
        mdl_q.delete();
        if (mdl_active) cur_skip = 1;
        mdl_active = 0;
        mdl_held   = '0;
    endtask

    task automatic finish_half(input logic lr);
        logic [WL-1:0] exp_tr;
        if (cur_valid && !cur_skip) begin
            exp_tr = (nbits == 0) ? '0 : (cur_exp >> (WL - nbits));
            check_eq(lr ? "word_right" : "word_left", {rx_extra, rx_word}, {1'b0, exp_tr});
        end
    endtask

    task automatic start_half(input logic lr);
        if (!lr) begin
            cur_half_len    = short_next_left ? 20 : FL / 2;
            short_next_left = 0;
            if (enable_i && !rst_i) begin
                mdl_active = 1;
                if (mdl_q.size() > 0) begin
                    pair_t p;
                    p        = mdl_q.pop_front();
                    cur_exp  = p.l;
                    mdl_held = p.r;
                    exp_taken++;
                end else begin
                    cur_exp  = '0;
                    mdl_held = '0;
                    exp_underrun++;
                end
            end else begin
                mdl_active = 0;
                cur_exp    = '0;
            end
        end else begin
            cur_half_len = FL / 2;
            cur_exp      = mdl_active ? mdl_held : '0;
        end
        cur_valid = 1; cur_skip = 0;
        rise_idx = 0; nbits = 0; rx_word = '0; rx_extra = 1'b0;
    endtask

    task automatic sample_rise();
        rise_idx++;
        if (rise_idx == 1) begin
            rx_extra = rx_extra | audio_data_o;
        end else if (rise_idx <= WL + 1) begin
            rx_word = {rx_word[WL-2:0], audio_data_o};
            nbits++;
        end else begin
            rx_extra = rx_extra | audio_data_o;
        end
    endtask

    // clock_generator stand-in: bclk = clk/14, lrclk toggles on a bclk fall
    initial begin
        forever begin
            @(negedge clk);
            tick++;
            if (tick == HALF_BCLK) begin
                tick = 0;
                if (bclk_i) begin
                    bclk_i = 1'b0;
                    fall_idx++;
                    if (fall_idx >= cur_half_len) begin
                        fall_idx = 0;
                        finish_half(lrclk_i);
                        lrclk_i = ~lrclk_i;
                        start_half(lrclk_i);
                    end
                end else begin
                    sample_rise();
                    bclk_i = 1'b1;
                end
            end
        end
    end

    // pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (pair_taken_o) got_taken++;
            if (underrun_o) got_underrun++;
            if (pair_taken_o && underrun_o) got_both++;
            if (!enable_i && !rst_i && (pair_taken_o || underrun_o)) idle_pulse++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // next half with the given lrclk value, at the given fall index
    task automatic wait_next(input logic lr, input int pos);
        int guard = 0;
        while (lrclk_i == lr && guard < GUARD) begin @(negedge clk); guard++; end
        while (!(lrclk_i == lr && fall_idx == pos) && guard < GUARD) begin @(negedge clk); guard++; end
        if (guard >= GUARD) check_eq("wait_next_timeout", 1, 0);
    endtask

    task automatic push_pair(input logic [WL-1:0] l, input logic [WL-1:0] r);
        int guard = 0;
        bit acc = 0;
        left_data_i = l; right_data_i = r; valid_i = 1'b1;
        while (!acc && guard < GUARD) begin
            acc = ready_o;
            @(negedge clk);
            guard++;
        end
        valid_i = 1'b0;
        if (acc) mdl_q.push_back({l, r});
        else     check_eq("push_timeout", 0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        wait_clks(5);
        check_eq("rst_sd", audio_data_o, 0);
        check_eq("rst_ready", ready_o, 0);
        check_eq("rst_taken", pair_taken_o, 0);
        check_eq("rst_underrun", underrun_o, 0);
        rst_i = 1'b0;
        wait_clks(3);
        check_eq("ready_disabled", ready_o, 0);

        // first pair pushed before the first left start
        wait_clks(40);
        enable_i = 1'b1;
        wait_clks(2);
        check_eq("ready_enabled", ready_o, 1);
        push_pair(24'h20F3FF, 24'hA5A5A5);
        wait_next(1, 5);
        wait_next(0, 5);
        wait_next(1, 5);
        check_eq("t1_taken", got_taken, 1);
        check_eq("t1_no_underrun", got_underrun, 0);

        // empty FIFO: underrun once per left start
        wait_next(0, 5);
        wait_next(0, 5);
        check_eq("t4_underruns", got_underrun, 2);

        // three back-to-back pairs into a two-deep FIFO
        wait_next(1, 5);
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        check_eq("t3_ready_full", ready_o, 0);
        push_pair($urandom, $urandom);
        check_eq("t3_taken_after_third", got_taken, 2);
        repeat (3) wait_next(0, 5);

        // randomized traffic
        repeat (6) begin
            wait_next(1, 4);
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) push_pair($urandom, $urandom);
        end
        repeat (2) wait_next(0, 5);

        // early LRCLK edge truncates the left word
        wait_next(1, 4);
        push_pair($urandom, $urandom);
        short_next_left = 1;
        wait_next(1, 5);
        wait_next(0, 5);

        // disable mid left word, re-enable mid right half
        wait_next(1, 4);
        push_pair($urandom, $urandom);
        wait_next(0, 8);
        enable_i = 1'b0;
        model_flush();
        wait_clks(2);
        check_eq("dis_sd", audio_data_o, 0);
        check_eq("dis_ready", ready_o, 0);
        wait_next(0, 5);
        wait_next(1, 10);
        enable_i = 1'b1;
        wait_clks(2);
        check_eq("reen_ready", ready_o, 1);
        push_pair($urandom, $urandom);
        wait_next(1, 5);
        wait_next(0, 5);

        // asynchronous reset in the middle of a left word
        wait_next(1, 4);
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        wait_next(0, 11);
        rst_i = 1'b1;
        model_flush();
        #1;
        check_eq("arst_sd", audio_data_o, 0);
        check_eq("arst_ready", ready_o, 0);
        check_eq("arst_taken", pair_taken_o, 0);
        wait_clks(3);
        rst_i = 1'b0;
        wait_clks(2);
        check_eq("post_rst_ready", ready_o, 1);
        wait_next(1, 5);
        push_pair($urandom, $urandom);
        wait_next(0, 5);
        wait_next(1, 5);
        wait_next(0, 5);

        check_eq("taken_total", got_taken, exp_taken);
        check_eq("underrun_total", got_underrun, exp_underrun);
        check_eq("pulse_overlap", got_both, 0);
        check_eq("idle_pulses", idle_pulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_i2s_transmitter
`default_nettype wire
